// File: rtl/pcie_csr_regfile.sv
// PCIe-subsystem CSR block: DFH, scratchpads, live status with sticky W1C errors.
// Optional ERR_LOG at +0x018 when PCIE_CSR_ERR_LOG_EN is defined.
module pcie_csr_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h10000,
    parameter int          ADDR_W      = 20,
    parameter int          NUM_SCRATCH = 1,
    parameter int          STAT_W      = 16,
    parameter int          ERR_W       = 8,
    parameter logic [63:0] DFH_VALUE   = 64'h3000_0000_1000_0020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [63:0]       csr_wdata,
    input  logic [7:0]        csr_byteen,
    output logic              csr_waitrequest,
    output logic [63:0]       csr_readdata,
    output logic              csr_readdatavalid,
    input  logic [STAT_W-1:0] stat_in,
    input  logic [ERR_W-1:0]  err_in
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_INIT;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        csr_waitrequest = 1'b1;
        case (state_reg)
            ST_INIT: state_next = ST_RUN;
            ST_RUN:  csr_waitrequest = 1'b0;
            default: state_next = ST_INIT;
        endcase
    end

    logic        rd_acc, wr_acc, in_win, wr_stat, mapped;
    logic [31:0] addr_ext, off32;
    logic [8:0]  word;
    logic [63:0] wmask, rd_mux, stat_word;
    logic        unused_ok;

    assign rd_acc   = csr_read  & ~csr_waitrequest;
    assign wr_acc   = csr_write & ~csr_waitrequest;
    assign addr_ext = 32'(csr_addr);
    assign off32    = addr_ext - BASE_ADDR;
    // Below-base addresses wrap to a huge offset, so both bounds are needed.
    assign in_win   = (addr_ext >= BASE_ADDR) && (off32 < 32'h1000);
    assign word     = off32[11:3];
    assign wr_stat  = wr_acc && in_win && (word == 9'd2);
    assign unused_ok = ^{off32[31:12], off32[2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mask
            assign wmask[8*gi +: 8] = {8{csr_byteen[gi]}};
        end
    endgenerate

    logic [63:0] scratch_q [NUM_SCRATCH];

    generate
        for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
            logic        hit;
            logic [63:0] q_reg;
            // +0x8 is a second window onto scratch 0.
            assign hit = wr_acc && in_win &&
                         ((word == 9'(32 + gi)) || ((gi == 0) && (word == 9'd1)));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   q_reg <= '0;
                else if (hit) q_reg <= (q_reg & ~wmask) | (csr_wdata & wmask);
            end
            assign scratch_q[gi] = q_reg;
        end
    endgenerate

    logic [STAT_W-1:0] stat_q_reg;
    logic [ERR_W-1:0]  sticky_reg, clr;

    assign clr = wr_stat ? (csr_wdata[32 +: ERR_W] & wmask[32 +: ERR_W]) : '0;

    // OR-ing err_in after the clear lets a coincident set win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q_reg <= '0;
            sticky_reg <= '0;
        end else begin
            stat_q_reg <= stat_in;
            sticky_reg <= (sticky_reg & ~clr) | err_in;
        end
    end

    always_comb begin
        stat_word                  = '0;
        stat_word[STAT_W-1:0]      = stat_q_reg;
        stat_word[32 +: ERR_W]     = sticky_reg;
    end

`ifdef PCIE_CSR_ERR_LOG_EN
    logic [63:0] errlog_reg, errlog_new;
    logic        wr_log;

    assign wr_log = wr_acc && in_win && (word == 9'd3) && csr_byteen[7] && csr_wdata[63];

    always_comb begin
        errlog_new              = '0;
        errlog_new[63]          = 1'b1;
        errlog_new[62]          = wr_acc;
        errlog_new[ADDR_W-1:0]  = csr_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            errlog_reg <= '0;
        else if (wr_log)
            errlog_reg <= '0;
        else if ((rd_acc || wr_acc) && !mapped && !errlog_reg[63])
            errlog_reg <= errlog_new;
    end
`endif

    always_comb begin
        rd_mux = '0;
        mapped = 1'b0;
        if (in_win) begin
            case (word)
                9'd0: begin rd_mux = DFH_VALUE;    mapped = 1'b1; end
                9'd1: begin rd_mux = scratch_q[0]; mapped = 1'b1; end
                9'd2: begin rd_mux = stat_word;    mapped = 1'b1; end
`ifdef PCIE_CSR_ERR_LOG_EN
                9'd3: begin rd_mux = errlog_reg;   mapped = 1'b1; end
`endif
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (word == 9'(32 + i)) begin
                            rd_mux = scratch_q[i];
                            mapped = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Snapshot at accept gives pre-write data for same-cycle read+write.
    logic        rd1_vld_reg, rd2_vld_reg;
    logic [63:0] rd1_data_reg, rd2_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_vld_reg       <= 1'b0;
            rd1_data_reg      <= '0;
            rd2_vld_reg       <= 1'b0;
            rd2_data_reg      <= '0;
            csr_readdatavalid <= 1'b0;
            csr_readdata      <= '0;
        end else begin
            rd1_vld_reg       <= rd_acc;
            rd1_data_reg      <= rd_mux;
            rd2_vld_reg       <= rd1_vld_reg;
            rd2_data_reg      <= rd1_data_reg;
            csr_readdatavalid <= rd2_vld_reg;
            if (rd2_vld_reg) csr_readdata <= rd2_data_reg;
        end
    end
endmodule
